// File: rtl/line_editor.sv
// Cursor-addressed edit line with insert/delete at cursor; Enter streams the line out over valid/ready.
// Optional macro LINE_EDITOR_CR_TERM_EN appends a 0x0D terminator byte to every committed line.
module line_editor #(
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   char_in,
    input  logic                         char_valid,
    input  logic                         left_cursor,
    input  logic                         right_cursor,
    input  logic                         Delete,
    input  logic                         Enter,
    output logic [7:0]                   out_char,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   cursor_pos,
    output logic [$clog2(DEPTH+1)-1:0]   line_len,
    output logic                         busy,
    output logic                         overflow
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);

    typedef enum logic [1:0] {S_EDIT, S_SEND, S_CLEAR} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   len_reg, cur_reg, idx_reg;
    logic            overflow_reg;
    logic [7:0]      buf_reg [DEPTH];
    logic [DEPTH-1:0][7:0] buf_next;

    logic edit_en, do_enter, do_char, do_insert, do_overflow;
    logic do_delete, do_left, do_right;
    logic handshake, send_last, enter_empty, clear_line;
    logic [PW-1:0] last_idx;

    // One action per cycle: lower-priority pulses are masked by any higher raw pulse.
    assign edit_en     = (state_reg == S_EDIT);
    assign do_enter    = edit_en & Enter;
    assign do_char     = edit_en & ~Enter & char_valid;
    assign do_insert   = do_char & (len_reg != DEPTH_W);
    assign do_overflow = do_char & (len_reg == DEPTH_W);
    assign do_delete   = edit_en & ~Enter & ~char_valid & Delete & (cur_reg < len_reg);
    assign do_left     = edit_en & ~Enter & ~char_valid & ~Delete & left_cursor
                         & (cur_reg != '0);
    assign do_right    = edit_en & ~Enter & ~char_valid & ~Delete & ~left_cursor
                         & right_cursor & (cur_reg < len_reg);

`ifdef LINE_EDITOR_CR_TERM_EN
    assign last_idx    = len_reg;
    assign enter_empty = 1'b0;
`else
    assign last_idx    = len_reg - PW'(1);
    assign enter_empty = (len_reg == '0);
`endif

    assign handshake  = (state_reg == S_SEND) & out_ready;
    assign send_last  = (idx_reg == last_idx);
    assign clear_line = (state_next == S_CLEAR) | (state_reg == S_CLEAR);

    // Each cell picks its neighbour value for the shift required by insert or delete.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cell
            logic [7:0] from_left, from_right;
            if (gi == 0) begin : g_first
                assign from_left = char_in;
            end else begin : g_mid_l
                assign from_left = buf_reg[gi-1];
            end
            if (gi == DEPTH - 1) begin : g_last
                assign from_right = 8'h00;
            end else begin : g_mid_r
                assign from_right = buf_reg[gi+1];
            end
            assign buf_next[gi] =
                (do_insert && (PW'(gi) == cur_reg)) ? char_in    :
                (do_insert && (PW'(gi) >  cur_reg)) ? from_left  :
                (do_delete && (PW'(gi) >= cur_reg)) ? from_right :
                                                      buf_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            buf_reg[i] <= buf_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_EDIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_EDIT:  if (do_enter) state_next = enter_empty ? S_CLEAR : S_SEND;
            S_SEND:  if (handshake && send_last) state_next = S_CLEAR;
            S_CLEAR: state_next = S_EDIT;
            default: state_next = S_EDIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg      <= '0;
            cur_reg      <= '0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= do_overflow;
            if (clear_line) begin
                len_reg <= '0;
                cur_reg <= '0;
            end else if (do_insert) begin
                len_reg <= len_reg + PW'(1);
                cur_reg <= cur_reg + PW'(1);
            end else if (do_delete) begin
                len_reg <= len_reg - PW'(1);
            end else if (do_left) begin
                cur_reg <= cur_reg - PW'(1);
            end else if (do_right) begin
                cur_reg <= cur_reg + PW'(1);
            end
            if (do_enter) begin
                idx_reg <= '0;
            end else if (handshake) begin
                idx_reg <= idx_reg + PW'(1);
            end
        end
    end

    always_comb begin
        out_valid  = (state_reg == S_SEND);
        out_last   = (state_reg == S_SEND) & send_last;
        busy       = (state_reg != S_EDIT);
        overflow   = overflow_reg;
        cursor_pos = cur_reg;
        line_len   = len_reg;
        out_char   = 8'h00;
        if (state_reg == S_SEND) begin
`ifdef LINE_EDITOR_CR_TERM_EN
            // idx can equal DEPTH only on the terminator slot, so the array read stays in range.
            out_char = (idx_reg == len_reg) ? 8'h0D : buf_reg[idx_reg[AW-1:0]];
`else
            out_char = buf_reg[idx_reg[AW-1:0]];
`endif
        end
    end

endmodule

// File: tb/tb_line_editor.sv
// Scoreboard bench for line_editor: a queue-based line model predicts every streamed byte.
module tb_line_editor;
    localparam int DEPTH = 16;
    localparam int PW = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    char_in = 8'h00;
    logic          char_valid = 1'b0;
    logic          left_cursor = 1'b0;
    logic          right_cursor = 1'b0;
    logic          Delete = 1'b0;
    logic          Enter = 1'b0;
    logic [7:0]    out_char;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic [PW-1:0] cursor_pos;
    logic [PW-1:0] line_len;
    logic          busy;
    logic          overflow;

    int n_checks = 0;
    int n_pass = 0;

    logic [8:0] sb_q[$];
    logic [7:0] model_q[$];
    int         model_cur = 0;

    bit         toggle_en = 1'b0;
    int         pat_k = 0;
    logic       ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    line_editor #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
        .left_cursor(left_cursor), .right_cursor(right_cursor), .Delete(Delete),
        .Enter(Enter), .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .cursor_pos(cursor_pos), .line_len(line_len),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (toggle_en) begin
            out_ready = ready_pat[pat_k];
            pat_k = (pat_k + 1) % 4;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Output monitor: a byte must match the queue head while offered, and is popped on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check("extra_byte", {31'd0, out_valid}, 32'd0);
            end else begin
                check(out_ready ? "byte" : "hold", {23'd0, out_last, out_char}, {23'd0, sb_q[0]});
                if (out_ready) begin
                    $display("tx char=%02h last=%0b", out_char, out_last);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic check_pos();
        check("line_len", {27'd0, line_len}, model_q.size());
        check("cursor_pos", {27'd0, cursor_pos}, model_cur);
    endtask

    task automatic edit_cycle(input logic cv, input logic [7:0] ch,
                              input logic l, input logic r, input logic d);
        bit full;
        full = (model_q.size() >= DEPTH);
        @(posedge clk); #1;
        char_valid = cv; char_in = ch; left_cursor = l; right_cursor = r; Delete = d;
        @(posedge clk); #1;
        char_valid = 1'b0; left_cursor = 1'b0; right_cursor = 1'b0; Delete = 1'b0;
        if (cv) begin
            if (!full) begin
                model_q.insert(model_cur, ch);
                model_cur++;
            end
        end else if (d) begin
            if (model_cur < model_q.size()) model_q.delete(model_cur);
        end else if (l) begin
            if (model_cur > 0) model_cur--;
        end else if (r) begin
            if (model_cur < model_q.size()) model_cur++;
        end
        check("overflow", {31'd0, overflow}, {31'd0, cv & full});
        $display("edit cv=%0b ch=%02h l=%0b r=%0b d=%0b len=%0d cur=%0d", cv, ch, l, r, d,
                 line_len, cursor_pos);
        check_pos();
    endtask

    task automatic ins(input logic [7:0] ch);
        edit_cycle(1'b1, ch, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter_line(input bit inject);
        int n;
        bit was_empty;
        n = model_q.size();
        was_empty = (n == 0);
        for (int i = 0; i < n; i++) begin
`ifdef LINE_EDITOR_CR_TERM_EN
            sb_q.push_back({1'b0, model_q[i]});
`else
            sb_q.push_back({(i == n - 1), model_q[i]});
`endif
        end
`ifdef LINE_EDITOR_CR_TERM_EN
        sb_q.push_back({1'b1, 8'h0D});
`endif
        model_q.delete();
        model_cur = 0;
        @(posedge clk); #1; Enter = 1'b1;
        @(posedge clk); #1; Enter = 1'b0;
        check("busy_after_enter", {31'd0, busy}, 32'd1);
`ifndef LINE_EDITOR_CR_TERM_EN
        if (was_empty) begin
            @(posedge clk); #1;
            check("empty_busy_one_cycle", {31'd0, busy}, 32'd0);
        end
`endif
        for (int i = 0; i < 200 && busy; i++) begin
            if (inject) begin
                char_valid = 1'b1;
                char_in = 8'h5A;
            end
            @(posedge clk); #1;
        end
        char_valid = 1'b0;
        check("send_done", {31'd0, busy}, 32'd0);
        check("drained", sb_q.size(), 32'd0);
        check_pos();
        $display("enter done empty=%0b", was_empty);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_char", {24'd0, out_char}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check_pos();

        // T1 plain line
        ins(8'h41); ins(8'h42); ins(8'h43);
        enter_line(1'b0);

        // T2 insert in the middle
        ins(8'h41); ins(8'h43);
        edit_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        ins(8'h42);
        enter_line(1'b0);

        // T3 delete at head, extra left is a no-op, right moves, delete at end is a no-op
        ins(8'h41); ins(8'h42); ins(8'h43);
        repeat (3) edit_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        edit_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        edit_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        edit_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        edit_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        edit_cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        edit_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        // priority: char wins over left, delete wins over left
        edit_cycle(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
        edit_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        edit_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        enter_line(1'b0);

        // T4 fill past capacity
        for (int i = 0; i <= DEPTH; i++) ins(8'h61 + 8'(i));
        edit_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        enter_line(1'b0);

        // empty-line Enter
        enter_line(1'b0);

        // T5 back-pressure plus dropped input while busy
        ins(8'h31); ins(8'h32); ins(8'h33);
        pat_k = 0;
        toggle_en = 1'b1;
        enter_line(1'b1);
        toggle_en = 1'b0;

        // T6 reset mid-send
        ins(8'h41); ins(8'h42); ins(8'h43);
        sb_q.push_back({1'b0, 8'h41});
        sb_q.push_back({1'b0, 8'h42});
        sb_q.push_back({1'b1, 8'h43});
        model_q.delete();
        model_cur = 0;
        @(posedge clk); #1; Enter = 1'b1;
        @(posedge clk); #1; Enter = 1'b0;
        for (int i = 0; i < 50 && sb_q.size() > 2; i++) begin
            @(posedge clk); #1;
        end
        check("first_byte_sent", sb_q.size(), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        sb_q.delete();
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check_pos();
        ins(8'h58);
        enter_line(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
